mux8_rr_arbiter: RTL
====================

// Module: mux8_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 8:1 mux output channel between 8 requesters.
//   Each requester raises req[i]. The block grants one owner at a time and drives the
//   mux select. The owner's data bit is routed to y until the owner drops its req.
//   Sits in front of the mux8x1 datapath and is its only source of the select value.
// PARAMETERS
//   TIMEOUT_CYC  16                    max BUSY cycles per grant (used only with MUX8_ARB_TIMEOUT_EN)
//   CNT_W        $clog2(TIMEOUT_CYC+1) hold-counter width (derived, do not override)
// PORTS
//   clk      in   1  single clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   req      in   8  per-requester request; held high for the whole ownership
//   data     in   8  per-requester data bit; data[i] belongs to requester i
//   gnt      out  8  one-hot grant, registered; all-zero when idle
//   sel      out  3  registered select to the mux; index of the current/last owner
//   busy     out  1  registered; 1 while a grant is held
//   y        out  1  busy ? data[sel] : 0 (combinational through the mux, no extra latency)
//   timeout  out  1  1-cycle pulse on forced release (tied 0 without MUX8_ARB_TIMEOUT_EN)
// BEHAVIOUR
//   Reset values: gnt=0, sel=0, busy=0, timeout=0, ptr=7, state=IDLE, hold count=0.
//     ptr=7 makes requester 0 the highest priority after reset.
//   States: IDLE, BUSY.
//   IDLE:
//     - If req (masked, see CONFIGURATION) is nonzero, pick the first set bit searching
//       ptr+1, ptr+2, ... mod 8.
//     - Next cycle: sel=winner, gnt=1<<winner, busy=1, state=BUSY.
//     - req=0: stay in IDLE, outputs unchanged (sel keeps its last value).
//   Latency: req rising in IDLE at edge N gives gnt/busy/y valid from edge N+1.
//   BUSY:
//     - While req[sel]=1: hold gnt and sel. Requests from other requesters are ignored;
//       there is no pre-emption.
//     - req[sel]=0 sampled: next cycle gnt=0, busy=0, ptr=sel, state=IDLE.
//   One mandatory IDLE cycle between grants, so the minimum grant period is 2 cycles.
//   Owner re-requests immediately: it has the lowest priority in the next arbitration.
//     It wins again only if no other req is set.
//   req bits set and then cleared while not granted are simply forgotten. No queuing.
//   Reset mid-BUSY: outputs return to reset values asynchronously and ptr=7.
//   gnt is always one-hot or zero. gnt[sel]==busy. Any violation is a bug.
// CONFIGURATION
//   MUX8_ARB_TIMEOUT_EN defined:
//     - The hold counter counts BUSY cycles.
//     - When it reaches TIMEOUT_CYC with req[sel] still 1, force a release: timeout=1 for
//       one cycle, ptr=sel, state=IDLE.
//     - Set lock[sel]. A locked requester is masked out of arbitration.
//     - lock[i] clears when req[i] is sampled 0.
//   Not defined: no counter, no lock mask, timeout=0, and ownership is unbounded.
// STRUCTURE
//   Package mux8_arb_pkg contains:
//     - N_REQ=8 and SEL_W=3
//     - the state enum {IDLE, BUSY}
//     - a function rr_pick(req, ptr) returning the 3-bit winner
//   Sub-module: one instance of mux8x1 (data, sel -> raw y). Output y = busy & raw y.
//   Arbitration, state, and counter logic are flat in this module.
// TESTING
//   Reset then req=8'h01 -> gnt=8'h01, sel=0, busy=1 one cycle later.
//     y follows data[0]; req drops -> busy=0 next cycle.
//   Reset then req=8'hFF held, each owner drops req after 2 BUSY cycles and re-raises
//     -> grant order 0,1,2,...,7,0 with one IDLE cycle between grants.
//   Owner 3 busy, req[5] rises -> gnt stays 8'h08 until req[3] drops, then gnt=8'h20.
//   rst pulsed mid-BUSY with owner 6 -> gnt=0, busy=0, y=0 immediately.
//     After release with req=8'h41 -> gnt=8'h01.
//   With MUX8_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, req=8'h11 held -> owner 0 released after
//     16 cycles, timeout pulses, gnt=8'h10. Requester 0 is not regranted until req[0]
//     toggles low.
//   Random req/data for 10k cycles -> gnt one-hot-or-zero, y==busy&data[sel], and no
//     starvation: every held req is granted within 8 grants.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux8_arb_pkg
//  Brief   : Shared constants, state type and round-robin pick function for
//            the 8-requester mux arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set bit searching ptr+1, ptr+2, ... wrapping; the pointer itself is checked last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux8x1.sv
`default_nettype none
// ============================================================================
//  Module  : mux8x1
//  Brief   : 8:1 single-bit datapath mux driven by the arbiter select.
//  Revision: 1.0 - initial release
// ============================================================================
module mux8x1
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = data[sel];

endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mux8_rr_arbiter
//  Brief   : Round-robin arbiter owning the select of an 8:1 mux; no pre-emption.
//            Optional hold timeout with requester lock: MUX8_ARB_TIMEOUT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             y,
    output logic             timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] w_req_eff;
    logic [SEL_W-1:0] w_win;
    logic             w_y_raw;

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_lock, w_lock_nxt;
    logic             r_timeout, w_timeout_nxt;

    // Requesters that were forcibly released stay out until they drop req.
    assign w_req_eff = req & ~r_lock;
    assign timeout   = r_timeout;
`else
    logic [CNT_W-1:0] w_unused_cnt;

    assign w_unused_cnt = CNT_W'(TIMEOUT_CYC);
    assign w_req_eff    = req;
    assign timeout      = 1'b0;
`endif

    assign w_win = rr_pick(w_req_eff, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
`ifdef MUX8_ARB_TIMEOUT_EN
        w_cnt_nxt     = '0;
        w_timeout_nxt = 1'b0;
        w_lock_nxt    = r_lock & req;
`endif
        case (r_state)
            IDLE: begin
                if (|w_req_eff) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                end
            end
            BUSY: begin
                if (!req[r_sel]) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_sel;
                end
`ifdef MUX8_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt       = IDLE;
                    w_gnt_nxt         = '0;
                    w_ptr_nxt         = r_sel;
                    w_timeout_nxt     = 1'b1;
                    w_lock_nxt[r_sel] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= SEL_W'(N_REQ - 1);
            r_sel   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_lock    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_lock    <= w_lock_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
`endif

    mux8x1 u_mux (
        .data (data),
        .sel  (r_sel),
        .y    (w_y_raw)
    );

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = (r_state == BUSY);
    assign y    = busy & w_y_raw;

endmodule
`default_nettype wire
